// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core with load-use bubble insertion.
// Optional performance counters are enabled by defining ID_EX_PERF_EN.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_hold_cnt
`endif
);

  logic              load_use_s;
  logic              ex_valid_d, ex_valid_q;
  logic [CTRL_W-1:0] ex_ctrl_d, ex_ctrl_q;
  logic [XLEN-1:0]   ex_pc_d, ex_pc_q, ex_rs1_data_d, ex_rs1_data_q;
  logic [XLEN-1:0]   ex_rs2_data_d, ex_rs2_data_q, ex_imm_d, ex_imm_q;
  logic [REG_AW-1:0] ex_rs1_d, ex_rs1_q, ex_rs2_d, ex_rs2_q, ex_rd_d, ex_rd_q;
  logic [2:0]        ex_funct3_d, ex_funct3_q;
  logic              ex_funct7b5_d, ex_funct7b5_q;

  // Load in EX (memRead, bit 5) whose destination is a non-x0 source of the ID instruction.
  always_comb begin
    load_use_s = ex_valid_q & ex_ctrl_q[5] & (ex_rd_q != {REG_AW{1'b0}}) & id_valid &
                 ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
    id_stall   = ~flush & (ex_hold | load_use_s);
  end

  // Next EX bundle: flush > hold > load-use bubble > load; data fields hold on bubbles.
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7b5_d = ex_funct7b5_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = {CTRL_W{1'b0}};
    end else if (ex_hold) begin
      ex_valid_d = ex_valid_q;
    end else if (load_use_s) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = {CTRL_W{1'b0}};
    end else begin
      ex_valid_d    = id_valid;
      ex_ctrl_d     = id_valid ? id_ctrl : {CTRL_W{1'b0}};
      ex_pc_d       = id_pc;
      ex_rs1_data_d = id_rs1_data;
      ex_rs2_data_d = id_rs2_data;
      ex_imm_d      = id_imm;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rd_d       = id_rd;
      ex_funct3_d   = id_funct3;
      ex_funct7b5_d = id_funct7b5;
    end
  end

  // Stage register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= {CTRL_W{1'b0}};
      ex_pc_q       <= {XLEN{1'b0}};
      ex_rs1_data_q <= {XLEN{1'b0}};
      ex_rs2_data_q <= {XLEN{1'b0}};
      ex_imm_q      <= {XLEN{1'b0}};
      ex_rs1_q      <= {REG_AW{1'b0}};
      ex_rs2_q      <= {REG_AW{1'b0}};
      ex_rd_q       <= {REG_AW{1'b0}};
      ex_funct3_q   <= 3'd0;
      ex_funct7b5_q <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_funct3   = ex_funct3_q;
  assign ex_funct7b5 = ex_funct7b5_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble_d, perf_bubble_q;
  logic [31:0] perf_flush_d, perf_flush_q;
  logic [31:0] perf_hold_d, perf_hold_q;

  // Wrapping event counters; flush masks both hold and bubble events.
  always_comb begin
    perf_bubble_d = perf_bubble_q;
    perf_flush_d  = perf_flush_q;
    perf_hold_d   = perf_hold_q;
    if (flush) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end else if (ex_hold) begin
      perf_hold_d = perf_hold_q + 32'd1;
    end else if (load_use_s) begin
      perf_bubble_d = perf_bubble_q + 32'd1;
    end else begin
      perf_bubble_d = perf_bubble_q;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_q <= 32'd0;
      perf_flush_q  <= 32'd0;
      perf_hold_q   <= 32'd0;
    end else begin
      perf_bubble_q <= perf_bubble_d;
      perf_flush_q  <= perf_flush_d;
      perf_hold_q   <= perf_hold_d;
    end
  end

  assign perf_bubble_cnt = perf_bubble_q;
  assign perf_flush_cnt  = perf_flush_q;
  assign perf_hold_cnt   = perf_hold_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed pipeline scenarios followed by randomized traffic.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_funct7b5, flush, ex_hold;
  logic [8:0]  id_ctrl;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_stall, ex_valid, ex_funct7b5;
  logic [8:0]  ex_ctrl;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_flush_cnt, perf_hold_cnt;
`endif

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5)
`ifdef ID_EX_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_hold_cnt(perf_hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [8:0] C_LW = 9'b111100000;
  localparam logic [8:0] C_R  = 9'b001000010;
  localparam logic [8:0] C_SW = 9'b100010000;
  localparam logic [8:0] C_BR = 9'b000001001;

  typedef struct {
    logic        v;
    logic [8:0]  ctrl;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] nb, nf, nh;
  } ex_t;

  ex_t m;
  ex_t q[$];
  int  vectors = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ex_t zero_state();
    ex_t z;
    z.v = 1'b0; z.ctrl = 9'd0; z.pc = 32'd0; z.a = 32'd0; z.b = 32'd0; z.imm = 32'd0;
    z.rs1 = 5'd0; z.rs2 = 5'd0; z.rd = 5'd0; z.f3 = 3'd0; z.f7 = 1'b0;
    z.nb = 32'd0; z.nf = 32'd0; z.nh = 32'd0;
    return z;
  endfunction

  // Reference: a load in EX writing a non-zero register read by a real ID instruction.
  function automatic logic model_hazard();
    return m.v && m.ctrl[5] && (m.rd != 5'd0) && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  task automatic set_id(input logic v, input logic [8:0] c, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] pc);
    id_valid = v; id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_pc = pc;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_funct3 = 3'($urandom_range(0, 7)); id_funct7b5 = 1'($urandom_range(0, 1));
  endtask

  // Called just after a falling edge with inputs set: checks id_stall, predicts the next bundle.
  task automatic apply();
    ex_t n;
    logic haz;
    #1;
    haz = model_hazard();
    check("id_stall", {31'd0, id_stall}, {31'd0, (!flush && (ex_hold || haz))});
    n = m;
    if (flush) begin
      n.v = 1'b0; n.ctrl = 9'd0; n.nf = n.nf + 32'd1;
    end else if (ex_hold) begin
      n.nh = n.nh + 32'd1;
    end else if (haz) begin
      n.v = 1'b0; n.ctrl = 9'd0; n.nb = n.nb + 32'd1;
    end else begin
      n.v = id_valid; n.ctrl = id_valid ? id_ctrl : 9'd0;
      n.pc = id_pc; n.a = id_rs1_data; n.b = id_rs2_data; n.imm = id_imm;
      n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.f3 = id_funct3; n.f7 = id_funct7b5;
    end
    m = n;
    q.push_back(n);
    @(negedge clk);
  endtask

  // Monitor: after each rising edge, compare the presented bundle with the oldest prediction.
  always @(posedge clk) begin
    ex_t e;
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
      check("ex_ctrl", {23'd0, ex_ctrl}, {23'd0, e.ctrl});
      if (e.v) begin
        check("ex_pc", ex_pc, e.pc);
        check("ex_rs1_data", ex_rs1_data, e.a);
        check("ex_rs2_data", ex_rs2_data, e.b);
        check("ex_imm", ex_imm, e.imm);
        check("ex_regs", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, e.rs1, e.rs2, e.rd});
        check("ex_funct", {28'd0, ex_funct3, ex_funct7b5}, {28'd0, e.f3, e.f7});
      end
`ifdef ID_EX_PERF_EN
      check("perf_bubble_cnt", perf_bubble_cnt, e.nb);
      check("perf_flush_cnt", perf_flush_cnt, e.nf);
      check("perf_hold_cnt", perf_hold_cnt, e.nh);
`endif
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    check({tag, "_ctrl"}, {23'd0, ex_ctrl}, 32'd0);
    check({tag, "_data"}, ex_pc | ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
    check({tag, "_fields"}, {15'd0, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5}, 32'd0);
    check({tag, "_stall"}, {31'd0, id_stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    set_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    m = zero_state();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Normal R-type flow.
    set_id(1'b1, C_R, 5'd1, 5'd2, 5'd5, 32'h100);
    apply();
    check("normal_pc", ex_pc, 32'h100);
    check("normal_ctrl", {23'd0, ex_ctrl}, {23'd0, C_R});

    // Load-use: LW x7, then a consumer of x7 on rs2 stalls once.
    set_id(1'b1, C_LW, 5'd1, 5'd2, 5'd7, 32'h104);
    apply();
    set_id(1'b1, C_R, 5'd3, 5'd7, 5'd8, 32'h108);
    apply();
    check("lu_bubble_ctrl", {23'd0, ex_ctrl}, 32'd0);
    apply();
    check("lu_loaded_rd", {27'd0, ex_rd}, 32'd8);

    // Load to x0 never stalls.
    set_id(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'h10c);
    apply();
    set_id(1'b1, C_R, 5'd0, 5'd4, 5'd9, 32'h110);
    apply();
    check("x0_loaded_pc", ex_pc, 32'h110);

    // Flush together with hold squashes and releases ID.
    flush = 1'b1; ex_hold = 1'b1;
    set_id(1'b1, C_SW, 5'd1, 5'd2, 5'd3, 32'h114);
    apply();
    flush = 1'b0; ex_hold = 1'b0;

    // Hold for three cycles with changing ID inputs.
    set_id(1'b1, C_BR, 5'd1, 5'd2, 5'd3, 32'h118);
    apply();
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, C_R, 5'(i), 5'(i + 1), 5'(i + 2), 32'h200 + 32'(i));
      apply();
      check("hold_pc", ex_pc, 32'h118);
    end
    ex_hold = 1'b0;

    // Reset asserted mid-stall clears everything asynchronously.
    set_id(1'b1, C_LW, 5'd1, 5'd2, 5'd7, 32'h120);
    apply();
    set_id(1'b1, C_R, 5'd7, 5'd1, 5'd2, 32'h124);
    #1;
    check("pre_reset_stall", {31'd0, id_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    q.delete();
    m = zero_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with a small register window to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      logic [8:0] c;
      case ($urandom_range(0, 4))
        0: c = C_LW;
        1: c = C_R;
        2: c = C_SW;
        3: c = C_BR;
        default: c = 9'($urandom);
      endcase
      set_id($urandom_range(0, 9) < 8, c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom);
      flush   = ($urandom_range(0, 9) == 0);
      ex_hold = ($urandom_range(0, 6) == 0);
      apply();
    end
    flush = 1'b0; ex_hold = 1'b0;
    @(negedge clk);
    check("scoreboard_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline stage register for the 5-stage RV32I core.
- Captures the decoder's 9-bit control mask and the operands and register indices from the ID stage.
- Detects load-use hazards against the instruction currently in EX and inserts bubbles.
- Honours flush (taken branch/jump resolved downstream) and hold (downstream stall).
- Presents a registered, valid-qualified bundle to the EX stage.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate
- REG_AW, 5, register index width
- CTRL_W, 9, control mask width. Bit order: ALUSrc[8], mem2Reg[7], regWrite[6], memRead[5], memWrite[4], branch[3], jump[2], ALUOp[1:0]

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  CTRL_W  decoder control mask
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data  in  XLEN  register file read port 1
- id_rs2_data  in  XLEN  register file read port 2
- id_imm  in  XLEN  sign-extended immediate
- id_rs1  in  REG_AW  source index 1
- id_rs2  in  REG_AW  source index 2
- id_rd  in  REG_AW  destination index
- id_funct3  in  3  funct3 field
- id_funct7b5  in  1  instr[30]
- flush  in  1  squash ID→EX transfer (taken branch/jump)
- ex_hold  in  1  downstream stall; freeze EX contents
- id_stall  out  1  ID/IF must hold their current instruction
- ex_valid  out  1  EX bundle valid
- ex_ctrl  out  CTRL_W  registered control mask
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered copies
- ex_rs1, ex_rs2, ex_rd  out  REG_AW each  registered copies
- ex_funct3  out  3  registered copy
- ex_funct7b5  out  1  registered copy

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including ex_valid=0 and ex_ctrl=0.
- id_stall is combinational and follows the hazard logic regardless of reset state.
- Latency: 1 cycle. ID inputs sampled on edge N appear on ex_* after edge N.
- Load-use hazard: load_use = ex_valid & ex_ctrl[5] & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)). All index comparisons are full REG_AW width.
- Per-edge update, priority high to low:
  1. flush=1: bubble. ex_valid=0, ex_ctrl=0; data fields don't-care, held at previous values. Flush overrides ex_hold.
  2. ex_hold=1: all ex_* retain their values.
  3. load_use=1: bubble. ex_valid=0, ex_ctrl=0.
  4. Otherwise: load all ID fields. ex_valid=id_valid; ex_ctrl = id_valid ? id_ctrl : 0.
- id_stall = ~flush & (ex_hold | load_use). Flush wins, so ID is never frozen while being squashed.
- Invariant: ex_valid=0 implies ex_ctrl=0. Downstream never sees regWrite, memWrite, branch or jump set on a bubble.
- Back-to-back loads: a hazard lasts exactly one cycle, because the bubble clears ex_valid.
- rd=x0 never causes a hazard.
- Reset asserted mid-stall clears all state. id_stall drops on the next evaluation because ex_valid=0.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- When defined, adds three outputs, each a 32-bit wrapping counter, reset to 0, incrementing once per clk edge while its condition is true:
  - perf_bubble_cnt: load-use bubbles inserted (load_use & ~flush & ~ex_hold)
  - perf_flush_cnt: cycles with flush=1
  - perf_hold_cnt: cycles with ex_hold=1 & ~flush
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with ex_valid=1 → all ex_* = 0 immediately, asynchronously; id_stall=0.
- Normal flow: id_valid=1, id_ctrl=9'b001000010 (R-type), id_rd=5, id_pc=0x100 → next cycle ex_valid=1, ex_ctrl=9'b001000010, ex_rd=5, ex_pc=0x100; id_stall=0.
- Load-use: EX holds LW (ex_ctrl=9'b111100000, ex_rd=7); ID has id_rs2=7 → id_stall=1 that cycle; next cycle ex_valid=0, ex_ctrl=0; following cycle the ID instruction loads and id_stall=0.
- x0 load: EX holds LW with ex_rd=0; ID has id_rs1=0 → id_stall=0; ID instruction loads normally.
- Flush vs hold: flush=1 and ex_hold=1 together with valid EX contents → next cycle ex_valid=0, ex_ctrl=0; id_stall=0 during that cycle.
- Hold: ex_hold=1 for 3 cycles with changing ID inputs → ex_* unchanged for all 3 cycles; id_stall=1 throughout. With ID_EX_PERF_EN defined, perf_hold_cnt increases by 3.
